wb_accel_dispatch: RTL and testbench

//  Wishbone slave front-end that sequences single Wishbone transactions onto the user-area targets:
//   - external memory (exmem)
//   - FIR AXI-Lite configuration port
//   - FIR AXI-Stream in/out
//   - MatMul AXI-Stream in/out

---
 rtl/wb_accel_dispatch.sv | 111 +++++++++++
 tb/tb_wb_accel_dispatch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/wb_accel_dispatch.sv
// wb_accel_dispatch: Wishbone slave sequencing single transactions onto exmem, FIR lite/stream and MatMul stream targets.
module wb_accel_dispatch #(
   parameter int EXMEM_DELAY = 10,
   parameter int SM_DELAY    = 10,
   parameter int TIMEOUT     = 255,
   parameter int CW          = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        exmem_en,
   input  logic [31:0] exmem_rdata,
   output logic        fir_lite_req,
   input  logic        fir_lite_rdy,
   input  logic [31:0] fir_lite_rdata,
   output logic        fir_ss_tvalid,
   input  logic        fir_ss_tready,
   input  logic        fir_sm_tvalid,
   input  logic [31:0] fir_sm_tdata,
   output logic        fir_sm_tready,
   output logic        mm_ss_tvalid,
   input  logic        mm_ss_tready,
   input  logic        mm_sm_tvalid,
   input  logic [31:0] mm_sm_tdata,
   output logic        mm_sm_tready,
   output logic        err_o
);
   typedef enum logic [2:0] {IDLE, EXMEM, LITE, SS, SM, ACK} state_t;
   state_t state, dec;
   logic [CW-1:0] dcnt, tcnt;
   logic mm, we, req, ss_v, sm_v, sm_r, done, fir_hit, mm_hit, unused_adr;
   logic [31:0] rdata;
   assign unused_adr = ^{wbs_adr_i[19:12], wbs_adr_i[6:0]};
   assign req = wbs_cyc_i & wbs_stb_i;
   assign exmem_en = req && state == EXMEM;
   assign fir_lite_req = req && state == LITE;
   assign ss_v = req && state == SS;
   assign fir_ss_tvalid = ss_v & ~mm;
   assign mm_ss_tvalid = ss_v & mm;
   assign sm_v = mm ? mm_sm_tvalid : fir_sm_tvalid;
   // the stream-out beat is taken only once the valid-qualified delay has elapsed
   assign sm_r = req && state == SM && sm_v && dcnt == CW'(SM_DELAY);
   assign fir_sm_tready = sm_r & ~mm;
   assign mm_sm_tready = sm_r & mm;
   assign fir_hit = wbs_adr_i[31:20] == 12'h300 && wbs_adr_i[11:8] == 4'h0;
   assign mm_hit = wbs_adr_i[31:20] == 12'h300 && wbs_adr_i[11:8] == 4'h1;
   always_comb begin
      dec = (wbs_sel_i == 4'h0) ? ACK :
            (wbs_adr_i[31:20] == 12'h380) ? EXMEM :
            (fir_hit && !wbs_adr_i[7]) ? LITE :
            (fir_hit || mm_hit) ? (wbs_we_i ? SS : SM) : ACK;
      done = (state == EXMEM) ? dcnt == CW'(EXMEM_DELAY) :
             (state == LITE) ? fir_lite_req & fir_lite_rdy :
             (state == SS) ? ss_v & (mm ? mm_ss_tready : fir_ss_tready) :
             (state == SM) ? sm_r : 1'b0;
      rdata = (state == EXMEM) ? exmem_rdata :
              (state == LITE) ? (we ? 32'h0 : fir_lite_rdata) :
              (state == SM) ? (mm ? mm_sm_tdata : fir_sm_tdata) : 32'h0;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         dcnt <= '0;
         tcnt <= '0;
         err_o <= 1'b0;
         wbs_dat_o <= 32'h0;
         wbs_ack_o <= 1'b0;
         mm <= 1'b0;
         we <= 1'b0;
      end else begin
         wbs_ack_o <= 1'b0;
         case (state)
            IDLE: if (req) begin
               state <= dec;
               mm <= mm_hit;
               we <= wbs_we_i;
               if (dec == ACK) begin
                  wbs_ack_o <= 1'b1;
                  wbs_dat_o <= 32'hDEAD_BEEF;
                  err_o <= 1'b1;
               end
            end
            ACK: state <= IDLE;
            default: begin
               // abort beats completion, completion beats the watchdog
               if (!wbs_cyc_i) begin
                  state <= IDLE;
                  dcnt <= '0;
                  tcnt <= '0;
               end else if (done || tcnt == CW'(TIMEOUT)) begin
                  state <= ACK;
                  wbs_ack_o <= 1'b1;
                  wbs_dat_o <= done ? rdata : 32'hFFFF_FFFF;
                  err_o <= err_o | ~done;
                  dcnt <= '0;
                  tcnt <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
                  if (state == EXMEM || (state == SM && sm_v)) dcnt <= dcnt + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_accel_dispatch.sv
// tb_wb_accel_dispatch: directed and random Wishbone transactions checked against a cycle-count reference model.
module tb_wb_accel_dispatch;
   localparam int EXMEM_DELAY = 10, SM_DELAY = 10, TIMEOUT = 255, NEVER = 1000;
   logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0] sel = 4'h0;
   logic [31:0] adr = 32'h0;
   logic ack, ex_en, lt_req, lt_rdy = 1'b0, fss_v, fss_r = 1'b0, fsm_v = 1'b0, fsm_r;
   logic mss_v, mss_r = 1'b0, msm_v = 1'b0, msm_r, err;
   logic [31:0] dat, ex_rd = 32'h0, lt_rd = 32'h0, fir_td = 32'h0, mm_td = 32'h0;
   logic e_err = 1'b0;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   wb_accel_dispatch #(.EXMEM_DELAY(EXMEM_DELAY), .SM_DELAY(SM_DELAY), .TIMEOUT(TIMEOUT), .CW(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat),
      .exmem_en(ex_en), .exmem_rdata(ex_rd), .fir_lite_req(lt_req), .fir_lite_rdy(lt_rdy),
      .fir_lite_rdata(lt_rd), .fir_ss_tvalid(fss_v), .fir_ss_tready(fss_r), .fir_sm_tvalid(fsm_v),
      .fir_sm_tdata(fir_td), .fir_sm_tready(fsm_r), .mm_ss_tvalid(mss_v), .mm_ss_tready(mss_r),
      .mm_sm_tvalid(msm_v), .mm_sm_tdata(mm_td), .mm_sm_tready(msm_r), .err_o(err));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask
   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      e_err = 1'b0;
   endtask
   // cycle 0 is the first cycle with cyc&stb; targets raise ready/valid at rdy_at/tv_at, master drops cyc at ab_at
   task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] s, input int rdy_at, input int tv_at, input int ab_at);
      int h, tmo, e_ack, e_end, e_smc, ack_c, acks, ex_n, lt_n, fss_n, mss_n, fsm_n, msm_n, sm_c;
      logic [31:0] e_dat, got_dat;
      logic is_ex, is_fir, is_mm, bad, lite, ss, sm, ok;
      is_ex = a[31:20] == 12'h380;
      is_fir = a[31:20] == 12'h300 && a[11:8] == 4'h0;
      is_mm = a[31:20] == 12'h300 && a[11:8] == 4'h1;
      bad = s == 4'h0 || !(is_ex || is_fir || is_mm);
      lite = !bad && is_fir && !a[7];
      ss = !bad && (is_mm || (is_fir && a[7])) && w;
      sm = !bad && (is_mm || (is_fir && a[7])) && !w;
      tmo = TIMEOUT + 1;
      h = is_ex ? EXMEM_DELAY + 1 : sm ? ((tv_at > 1) ? tv_at : 1) + SM_DELAY : ((rdy_at > 1) ? rdy_at : 1);
      ok = 1'b0;
      e_dat = 32'h0;
      if (bad) begin
         e_ack = 1; e_dat = 32'hDEAD_BEEF; e_err = 1'b1; e_end = 0;
      end else if (ab_at <= h && ab_at <= tmo) begin
         e_ack = -1; e_end = ab_at - 1;
      end else if (h <= tmo) begin
         ok = 1'b1; e_ack = h + 1; e_end = h;
         e_dat = is_ex ? ex_rd : lite ? (w ? 32'h0 : lt_rd) : sm ? (is_mm ? mm_td : fir_td) : 32'h0;
      end else begin
         e_ack = tmo + 1; e_dat = 32'hFFFF_FFFF; e_err = 1'b1; e_end = tmo;
      end
      e_smc = (sm && ok) ? h : -1;
      ack_c = -1; acks = 0; ex_n = 0; lt_n = 0; fss_n = 0; mss_n = 0; fsm_n = 0; msm_n = 0; sm_c = -1;
      got_dat = 32'h0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         cyc = ack_c < 0 && c < ab_at;
         stb = cyc; we = w; sel = s; adr = a;
         lt_rdy = c >= rdy_at; fss_r = c >= rdy_at; mss_r = c >= rdy_at;
         fsm_v = c >= tv_at; msm_v = c >= tv_at;
         @(negedge clk);
         if (ack) begin
            acks++;
            if (ack_c < 0) begin ack_c = c; got_dat = dat; end
         end
         ex_n += int'(ex_en); lt_n += int'(lt_req);
         fss_n += int'(fss_v & fss_r); mss_n += int'(mss_v & mss_r);
         fsm_n += int'(fsm_r & fsm_v); msm_n += int'(msm_r & msm_v);
         if (fsm_r | msm_r) sm_c = c;
         if ((ack_c >= 0 && c > ack_c) || c > ab_at + 2) break;
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; lt_rdy = 1'b0; fss_r = 1'b0; mss_r = 1'b0; fsm_v = 1'b0; msm_v = 1'b0;
      chk("ack_cycle", 32'(ack_c), 32'(e_ack));
      chk("ack_count", 32'(acks), (e_ack >= 0) ? 32'd1 : 32'd0);
      if (e_ack >= 0) chk("ack_data", got_dat, e_dat);
      chk("exmem_en_cycles", 32'(ex_n), (is_ex && !bad) ? 32'(e_end) : 32'd0);
      chk("lite_req_cycles", 32'(lt_n), lite ? 32'(e_end) : 32'd0);
      chk("fir_ss_beats", 32'(fss_n), (ss && is_fir && ok) ? 32'd1 : 32'd0);
      chk("mm_ss_beats", 32'(mss_n), (ss && is_mm && ok) ? 32'd1 : 32'd0);
      chk("fir_sm_beats", 32'(fsm_n), (sm && is_fir && ok) ? 32'd1 : 32'd0);
      chk("mm_sm_beats", 32'(msm_n), (sm && is_mm && ok) ? 32'd1 : 32'd0);
      chk("sm_ready_cycle", 32'(sm_c), 32'(e_smc));
      chk("err_sticky", {31'h0, err}, {31'h0, e_err});
   endtask
   initial begin
      int k, rdy, tv, ab;
      logic [31:0] a;
      logic [3:0] s;
      int sm_pulses, ack_seen;
      do_reset();
      @(negedge clk);
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_dat", dat, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_strobes", {26'h0, ex_en, lt_req, fss_v, mss_v, fsm_r, msm_r}, 32'h0);
      ex_rd = 32'h1234_5678; lt_rd = 32'hC0FF_EE01; fir_td = 32'h0000_00A5; mm_td = 32'h5A5A_0077;
      xact(32'h3800_0010, 1'b1, 4'hF, NEVER, NEVER, NEVER);
      xact(32'h3800_0010, 1'b0, 4'hF, NEVER, NEVER, NEVER);
      xact(32'h3000_0080, 1'b1, 4'hF, 0, NEVER, NEVER);
      xact(32'h3000_0080, 1'b1, 4'hF, 6, NEVER, NEVER);
      xact(32'h3000_0084, 1'b0, 4'hF, NEVER, 3, NEVER);
      xact(32'h3000_0010, 1'b0, 4'hF, 2, NEVER, NEVER);
      xact(32'h3000_0010, 1'b1, 4'h3, 4, NEVER, NEVER);
      xact(32'h3000_0100, 1'b1, 4'hF, 3, NEVER, NEVER);
      xact(32'h3000_0104, 1'b0, 4'hF, NEVER, 0, NEVER);
      xact(32'h3000_0300, 1'b0, 4'hF, NEVER, NEVER, NEVER);
      do_reset();
      xact(32'h3800_0010, 1'b0, 4'h0, NEVER, NEVER, NEVER);
      do_reset();
      xact(32'h3000_0104, 1'b0, 4'hF, NEVER, NEVER, NEVER);
      do_reset();
      xact(32'h3800_0010, 1'b0, 4'hF, NEVER, NEVER, 4);
      xact(32'h3800_0010, 1'b0, 4'hF, NEVER, NEVER, NEVER);
      xact(32'h3000_0080, 1'b1, 4'hF, 3, NEVER, 3);
      // synchronous reset during a FIR stream-out wait: no beat, no ack, outputs back to reset values
      sm_pulses = 0; ack_seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         rst = c == 8; cyc = c <= 8; stb = cyc; we = 1'b0; sel = 4'hF; adr = 32'h3000_0084;
         fsm_v = c >= 3;
         @(negedge clk);
         sm_pulses += int'(fsm_r | msm_r);
         ack_seen += int'(ack);
      end
      #1 fsm_v = 1'b0; rst = 1'b0;
      chk("rst_mid_sm_tready", 32'(sm_pulses), 32'd0);
      chk("rst_mid_sm_ack", 32'(ack_seen), 32'd0);
      chk("rst_mid_sm_dat", dat, 32'h0);
      chk("rst_mid_sm_err", {31'h0, err}, 32'h0);
      e_err = 1'b0;
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 5);
         a = $urandom;
         case (k)
            0: a[31:20] = 12'h380;
            1: begin a[31:20] = 12'h300; a[11:7] = 5'b00000; end
            2: begin a[31:20] = 12'h300; a[11:7] = 5'b00001; end
            3: begin a[31:20] = 12'h300; a[11:8] = 4'h1; end
            4: begin a[31:20] = 12'h300; a[11:8] = 4'(2 + $urandom_range(0, 13)); end
            default: a[31:20] = 12'h3A5;
         endcase
         s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         rdy = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 6);
         tv = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 6);
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 14) : NEVER;
         ex_rd = $urandom; lt_rd = $urandom; fir_td = $urandom; mm_td = $urandom;
         xact(a, 1'($urandom_range(0, 1)), s, rdy, tv, ab);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
